// File: rtl/rename_free_list_ctrl_if.sv
// Handshake bundle between the rename free-list sequencer and its neighbours
// (dispatch, commit, flush source and the physical free list itself).
interface rename_free_list_ctrl_if #(
    parameter int PR_W  = 6,
    parameter int CNT_W = 6
);
    logic             disp_req;
    logic             disp_grant;
    logic             fl_empty;
    logic [PR_W-1:0]  fl_p_rd_new;
    logic             fl_reg_wen;
    logic             ret_valid;
    logic [PR_W-1:0]  ret_p_rd_old;
    logic             fl_retire_reg;
    logic [PR_W-1:0]  fl_p_rd_old;
    logic             flush_req;
    logic [CNT_W-1:0] flush_cnt;
    logic             fl_stall_recover;
    logic             fl_recover;
    logic [PR_W-1:0]  fl_PR_new_flush;
    logic             busy;
    logic [CNT_W-1:0] hist_cnt;
    logic             err;

    modport master (
        output disp_req, fl_empty, fl_p_rd_new, ret_valid, ret_p_rd_old,
               flush_req, flush_cnt,
        input  disp_grant, fl_reg_wen, fl_retire_reg, fl_p_rd_old,
               fl_stall_recover, fl_recover, fl_PR_new_flush, busy, hist_cnt, err
    );

    modport slave (
        input  disp_req, fl_empty, fl_p_rd_new, ret_valid, ret_p_rd_old,
               flush_req, flush_cnt,
        output disp_grant, fl_reg_wen, fl_retire_reg, fl_p_rd_old,
               fl_stall_recover, fl_recover, fl_PR_new_flush, busy, hist_cnt, err
    );
endinterface

// File: rtl/rename_free_list_ctrl.sv
// Physical-register free-list sequencer: gates allocation, forwards retire frees,
// keeps a program-order allocation history and walks squashed PRs back on flush.
module rename_free_list_ctrl #(
    parameter int PR_W       = 6,
    parameter int HIST_DEPTH = 32,
    parameter int CNT_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    rename_free_list_ctrl_if.slave bus
);
    localparam int               PTR_W   = $clog2(HIST_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(HIST_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_WALK  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic [PR_W-1:0]  hist_q [HIST_DEPTH];

    logic             grant_s;
    logic             ret_pop_s;
    logic             walk_pop_s;
    logic [CNT_W-1:0] avail_s;
    logic [CNT_W-1:0] flush_n_s;
    logic [PR_W-1:0]  walk_pr_s;

    // Request qualification; a retire may not consume entries already marked for the walk.
    always_comb begin
        grant_s    = bus.disp_req & ~bus.fl_empty & (cnt_q < DEPTH_C) &
                     (state_q == ST_RUN) & ~bus.flush_req & ~rst;
        ret_pop_s  = bus.ret_valid & (cnt_q != {CNT_W{1'b0}}) &
                     ~((state_q != ST_RUN) & (cnt_q <= rem_q));
        walk_pop_s = (state_q == ST_WALK);
        avail_s    = cnt_q - CNT_W'(ret_pop_s);
        if (bus.flush_cnt < avail_s) begin
            flush_n_s = bus.flush_cnt;
        end else begin
            flush_n_s = avail_s;
        end
        walk_pr_s  = hist_q[tail_q - PTR_W'(1)];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and walk-count logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req && (flush_n_s != {CNT_W{1'b0}})) begin
                    state_d = ST_STALL;
                    rem_d   = flush_n_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                state_d = ST_WALK;
            end
            ST_WALK: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WALK;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pointer, occupancy and sticky-error updates.
    always_comb begin
        head_d = head_q + PTR_W'(ret_pop_s);
        if (grant_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else if (walk_pop_s) begin
            tail_d = tail_q - PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        cnt_d = cnt_q + CNT_W'(grant_s) - CNT_W'(ret_pop_s) - CNT_W'(walk_pop_s);
        err_d = err_q | (bus.ret_valid & ~ret_pop_s) |
                (bus.flush_req & (state_q != ST_RUN));
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
            rem_q  <= {CNT_W{1'b0}};
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            err_q  <= err_d;
        end
    end

    // History storage; contents are only read behind valid pointers so no reset.
    always_ff @(posedge clk) begin
        if (grant_s) begin
            hist_q[tail_q] <= bus.fl_p_rd_new;
        end
    end

    // Output decode from registered state; pass-throughs forced low while in reset.
    always_comb begin
        bus.disp_grant       = grant_s;
        bus.fl_reg_wen       = grant_s;
        bus.fl_retire_reg    = bus.ret_valid & ~rst;
        bus.fl_p_rd_old      = rst ? {PR_W{1'b0}} : bus.ret_p_rd_old;
        bus.fl_stall_recover = (state_q == ST_STALL);
        bus.fl_recover       = (state_q == ST_WALK);
        bus.busy             = (state_q != ST_RUN);
        bus.fl_PR_new_flush  = (state_q == ST_WALK) ? walk_pr_s : {PR_W{1'b0}};
        bus.hist_cnt         = cnt_q;
        bus.err              = err_q;
    end
endmodule

// File: tb/tb_rename_free_list_ctrl.sv
// Self-checking bench for rename_free_list_ctrl: queue-based reference model,
// directed scenarios plus randomized traffic.
module tb_rename_free_list_ctrl;
    localparam int PR_W  = 6;
    localparam int CNT_W = 6;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rename_free_list_ctrl_if #(.PR_W(PR_W), .CNT_W(CNT_W)) bus ();

    rename_free_list_ctrl #(.PR_W(PR_W), .HIST_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: history as a queue (front = oldest allocation).
    int   hq[$];
    int   mode;      // 0 run, 1 stall, 2 walk
    int   rem;
    logic m_err;
    logic [24:0] exp_v;

    function automatic logic [24:0] obs_v();
        return {bus.disp_grant, bus.fl_reg_wen, bus.fl_retire_reg, bus.fl_stall_recover,
                bus.fl_recover, bus.busy, bus.err, bus.hist_cnt, bus.fl_PR_new_flush,
                bus.fl_p_rd_old};
    endfunction

    task automatic model_reset();
        hq.delete();
        mode  = 0;
        rem   = 0;
        m_err = 1'b0;
    endtask

    task automatic model_comb();
        logic g;
        logic [PR_W-1:0] wpr;
        g   = bus.disp_req && !bus.fl_empty && (hq.size() < DEPTH) && mode == 0 && !bus.flush_req;
        wpr = (mode == 2) ? PR_W'(hq[$]) : PR_W'(0);
        exp_v = {g, g, bus.ret_valid, (mode == 1), (mode == 2), (mode != 0), m_err,
                 CNT_W'(hq.size()), wpr, bus.ret_p_rd_old};
    endtask

    task automatic model_seq();
        int sz, n;
        logic g, rp;
        sz = hq.size();
        g  = bus.disp_req && !bus.fl_empty && sz < DEPTH && mode == 0 && !bus.flush_req;
        rp = bus.ret_valid && sz > 0 && !(mode != 0 && sz <= rem);
        if (bus.ret_valid && !rp) m_err = 1'b1;
        if (bus.flush_req && mode != 0) m_err = 1'b1;
        if (rp) void'(hq.pop_front());
        case (mode)
            0: if (bus.flush_req) begin
                n = int'(bus.flush_cnt);
                if (n > sz - int'(rp)) n = sz - int'(rp);
                if (n > 0) begin
                    rem  = n;
                    mode = 1;
                end
            end
            1: mode = 2;
            2: begin
                void'(hq.pop_back());
                rem = rem - 1;
                if (rem == 0) mode = 0;
            end
            default: mode = 0;
        endcase
        if (g) hq.push_back(int'(bus.fl_p_rd_new));
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_comb();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req     = 1'b0;
        bus.fl_empty     = 1'b0;
        bus.fl_p_rd_new  = {PR_W{1'b0}};
        bus.ret_valid    = 1'b0;
        bus.ret_p_rd_old = {PR_W{1'b0}};
        bus.flush_req    = 1'b0;
        bus.flush_cnt    = {CNT_W{1'b0}};
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.disp_req     = 1'b1;
        bus.ret_valid    = 1'b1;
        bus.ret_p_rd_old = 6'd17;
        rst = 1'b1;
        model_reset();
        #3;
        total++;
        if (obs_v() !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs_v(), 25'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_inputs();
        cyc_begin();
        total++;
        if (obs_v() !== exp_v) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs_v(), exp_v);
        end
        cyc_end();
    endtask

    task automatic test_alloc();
        for (int i = 0; i < 5; i++) begin
            bus.disp_req    = 1'b1;
            bus.fl_empty    = 1'b0;
            bus.fl_p_rd_new = PR_W'(32 + i);
            cyc_begin();
            total++;
            if (obs_v() !== exp_v || bus.fl_reg_wen !== 1'b1) begin
                bad++;
                $display("FAIL alloc cycle=%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            cyc_end();
        end
        idle_inputs();
        cyc_begin();
        total++;
        if (bus.hist_cnt !== 6'd5 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL alloc_count got cnt=%0d err=%b want cnt=5 err=0", bus.hist_cnt, bus.err);
        end
        cyc_end();
    endtask

    task automatic test_empty();
        for (int i = 0; i < 3; i++) begin
            bus.disp_req = 1'b1;
            bus.fl_empty = 1'b1;
            cyc_begin();
            total++;
            if (obs_v() !== exp_v || bus.disp_grant !== 1'b0 || bus.hist_cnt !== 6'd5) begin
                bad++;
                $display("FAIL empty_block cycle=%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            cyc_end();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int walked[$];
        int exp_w[3] = '{36, 35, 34};
        int busy_cycles = 0;
        int early_grants = 0;
        bus.disp_req    = 1'b1;
        bus.fl_p_rd_new = 6'd50;
        bus.flush_req   = 1'b1;
        bus.flush_cnt   = 6'd3;
        cyc_begin();
        total++;
        if (obs_v() !== exp_v) begin
            bad++;
            $display("FAIL flush_edge got=%h want=%h", obs_v(), exp_v);
        end
        cyc_end();
        bus.flush_req = 1'b0;
        bus.flush_cnt = 6'd0;
        for (int c = 1; c <= 5; c++) begin
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL flush_seq cycle=%0d got=%h want=%h", c, obs_v(), exp_v);
            end
            if (bus.fl_recover === 1'b1) walked.push_back(int'(bus.fl_PR_new_flush));
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.busy === 1'b1 && bus.disp_grant === 1'b1) early_grants++;
            if (c == 1) begin
                total++;
                if (bus.fl_stall_recover !== 1'b1) begin
                    bad++;
                    $display("FAIL flush_stall got=%b want=1", bus.fl_stall_recover);
                end
            end
            if (c == 5) begin
                total++;
                if (bus.busy !== 1'b0 || bus.hist_cnt !== 6'd2 || bus.disp_grant !== 1'b1) begin
                    bad++;
                    $display("FAIL flush_done got busy=%b cnt=%0d grant=%b want 0/2/1",
                             bus.busy, bus.hist_cnt, bus.disp_grant);
                end
            end
            cyc_end();
        end
        idle_inputs();
        total++;
        if (walked.size() != 3 || busy_cycles != 4 || early_grants != 0) begin
            bad++;
            $display("FAIL flush_walk got n=%0d busy=%0d grants=%0d want 3/4/0",
                     walked.size(), busy_cycles, early_grants);
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (walked[k] != exp_w[k]) begin
                    bad++;
                    $display("FAIL flush_pr idx=%0d got=%0d want=%0d", k, walked[k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_retire();
        int guard = 0;
        bus.disp_req     = 1'b1;
        bus.fl_p_rd_new  = 6'd51;
        bus.ret_valid    = 1'b1;
        bus.ret_p_rd_old = 6'd31;
        cyc_begin();
        total++;
        if (obs_v() !== exp_v || bus.fl_retire_reg !== 1'b1 || bus.fl_p_rd_old !== 6'd31) begin
            bad++;
            $display("FAIL retire_pass got=%h want=%h", obs_v(), exp_v);
        end
        cyc_end();
        idle_inputs();
        cyc_begin();
        total++;
        if (bus.hist_cnt !== 6'd3) begin
            bad++;
            $display("FAIL retire_push_cnt got=%0d want=3", bus.hist_cnt);
        end
        cyc_end();
        while (hq.size() > 0 && guard < 40) begin
            bus.ret_valid = 1'b1;
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL retire_drain got=%h want=%h", obs_v(), exp_v);
            end
            cyc_end();
            guard++;
        end
        bus.ret_valid = 1'b1;
        cyc_begin();
        cyc_end();
        idle_inputs();
        cyc_begin();
        total++;
        if (bus.err !== 1'b1 || bus.hist_cnt !== 6'd0) begin
            bad++;
            $display("FAIL retire_empty_err got err=%b cnt=%0d want err=1 cnt=0", bus.err, bus.hist_cnt);
        end
        cyc_end();
    endtask

    task automatic test_wrap();
        int snap[$];
        int walked[$];
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bus.disp_req    = 1'b1;
            bus.fl_p_rd_new = PR_W'($urandom_range(0, 63));
            bus.ret_valid   = (i % 2 == 1);
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL wrap_mix cycle=%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            cyc_end();
        end
        bus.ret_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.disp_req    = 1'b1;
            bus.fl_p_rd_new = PR_W'($urandom_range(0, 63));
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL wrap_fill cycle=%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            if (i == 14) begin
                total++;
                if (bus.disp_grant !== 1'b0 || bus.hist_cnt !== 6'd32) begin
                    bad++;
                    $display("FAIL wrap_full got grant=%b cnt=%0d want 0/32", bus.disp_grant, bus.hist_cnt);
                end
            end
            cyc_end();
        end
        snap = hq;
        idle_inputs();
        bus.flush_req = 1'b1;
        bus.flush_cnt = 6'd40;
        for (int c = 0; c < 36; c++) begin
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL wrap_walk cycle=%0d got=%h want=%h", c, obs_v(), exp_v);
            end
            if (bus.fl_recover === 1'b1) walked.push_back(int'(bus.fl_PR_new_flush));
            cyc_end();
            bus.flush_req = 1'b0;
            bus.flush_cnt = 6'd0;
        end
        total++;
        if (walked.size() != 32 || bus.hist_cnt !== 6'd0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap_clamp got n=%0d cnt=%0d busy=%b want 32/0/0",
                     walked.size(), bus.hist_cnt, bus.busy);
        end else begin
            for (int k = 0; k < 32; k++) begin
                total++;
                if (walked[k] != snap[31 - k]) begin
                    bad++;
                    $display("FAIL wrap_order idx=%0d got=%0d want=%0d", k, walked[k], snap[31 - k]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.disp_req     = ($urandom_range(0, 2) != 0);
            bus.fl_empty     = ($urandom_range(0, 7) == 0);
            bus.fl_p_rd_new  = PR_W'($urandom_range(0, 63));
            bus.ret_valid    = ($urandom_range(0, 2) == 0);
            bus.ret_p_rd_old = PR_W'($urandom_range(0, 63));
            bus.flush_req    = ($urandom_range(0, 9) == 0);
            bus.flush_cnt    = CNT_W'($urandom_range(0, 40));
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL random cycle=%0d got=%h want=%h", i, obs_v(), exp_v);
            end
            cyc_end();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.disp_req    = 1'b1;
            bus.fl_p_rd_new = PR_W'(10 + i);
            cyc_begin();
            cyc_end();
        end
        idle_inputs();
        bus.flush_req = 1'b1;
        bus.flush_cnt = 6'd3;
        cyc_begin();
        cyc_end();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            cyc_begin();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL areset_pre cycle=%0d got=%h want=%h", c, obs_v(), exp_v);
            end
            cyc_end();
        end
        total++;
        if (bus.fl_recover !== 1'b1) begin
            bad++;
            $display("FAIL areset_in_walk got=%b want=1", bus.fl_recover);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.fl_recover !== 1'b0 || bus.busy !== 1'b0 || bus.hist_cnt !== 6'd0 ||
            bus.fl_PR_new_flush !== 6'd0 || bus.fl_stall_recover !== 1'b0) begin
            bad++;
            $display("FAIL areset_outputs got rec=%b busy=%b cnt=%0d pr=%0d want all 0",
                     bus.fl_recover, bus.busy, bus.hist_cnt, bus.fl_PR_new_flush);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.disp_req    = 1'b1;
        bus.fl_p_rd_new = 6'd7;
        cyc_begin();
        total++;
        if (obs_v() !== exp_v || bus.disp_grant !== 1'b1 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL areset_resume got=%h want=%h", obs_v(), exp_v);
        end
        cyc_end();
        idle_inputs();
        cyc_begin();
        total++;
        if (bus.hist_cnt !== 6'd1) begin
            bad++;
            $display("FAIL areset_count got=%0d want=1", bus.hist_cnt);
        end
        cyc_end();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_empty();
        test_flush();
        test_retire();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rename_free_list_ctrl.md
Name: rename_free_list_ctrl

Overview:
Sequencer for the physical-register free list in the OoO pipe. It gates dispatch allocation requests onto the free list's reg_wen and forwards retire frees. It records every allocated PR in program order in a history FIFO. On a flush it drives the stall_recover/recover handshake, walking the youngest allocations back to the free list one per cycle while stalling dispatch.

Parameters:
PR_W, 6, physical register index width
HIST_DEPTH, 32, history FIFO entries (power of 2, ≥ in-flight allocations)
CNT_W, 6, width of counts; holds 0..HIST_DEPTH inclusive

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
disp_req  in  1  dispatch needs a new destination PR this cycle
disp_grant  out  1  allocation performed this cycle
fl_empty  in  1  free list empty flag
fl_p_rd_new  in  PR_W  PR the free list hands out this cycle
fl_reg_wen  out  1  allocate strobe to free list
ret_valid  in  1  commit frees a PR
ret_p_rd_old  in  PR_W  PR freed by commit
fl_retire_reg  out  1  retire strobe to free list
fl_p_rd_old  out  PR_W  PR returned by retire
flush_req  in  1  squash youngest flush_cnt allocations (1-cycle pulse)
flush_cnt  in  CNT_W  number of allocations to squash
fl_stall_recover  out  1  recovery prep cycle to free list
fl_recover  out  1  recovery-walk strobe to free list
fl_PR_new_flush  out  PR_W  PR returned during walk
busy  out  1  recovery in progress; front end holds dispatch
hist_cnt  out  CNT_W  current history occupancy
err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1): state=RUN; head=tail=0; hist_cnt=0; remaining=0; err=0. All outputs 0 immediately, including fl_recover/fl_stall_recover when reset arrives mid-walk.
- States: RUN, STALL, WALK. All three are decoded from registered state, not from inputs.
  - fl_stall_recover = (state==STALL).
  - fl_recover = (state==WALK).
  - busy = (state!=RUN).
- Allocation (combinational):
  - disp_grant = disp_req & ~fl_empty & (hist_cnt<HIST_DEPTH) & (state==RUN) & ~flush_req.
  - fl_reg_wen = disp_grant.
  - On grant, hist[tail] <= fl_p_rd_new at the edge, then tail++ mod HIST_DEPTH.
- Retire (combinational pass-through in all states):
  - fl_retire_reg = ret_valid; fl_p_rd_old = ret_p_rd_old.
  - Retire pops the head at the edge: head++.
  - If hist_cnt==0, or if state!=RUN and hist_cnt ≤ remaining (retire would hit a flushed entry): do not pop, set err.
- Flush in RUN:
  - n = min(flush_cnt, hist_cnt − (ret_valid ? 1 : 0)).
  - n==0: remain RUN, no handshake.
  - n>0: remaining <= n, next state STALL.
- STALL: exactly 1 cycle, then WALK.
- WALK, each cycle:
  - fl_PR_new_flush = hist[tail−1].
  - At the edge: tail--, remaining--.
  - When remaining==1 at the edge, next state RUN.
  - busy drops the cycle after the last walk cycle.
- fl_PR_new_flush = 0 outside WALK.
- flush_req while state!=RUN is ignored and sets err.
- hist_cnt updates at the edge:
  - +1 on push, −1 on each pop (retire pop, walk pop).
  - Push + retire in the same cycle: unchanged.
  - Retire + walk pop in the same cycle: −2.
- Pointers wrap modulo HIST_DEPTH. Full (hist_cnt==HIST_DEPTH) blocks grant only. Empty blocks retire pop only.
- Flush latency: flush_req at edge k → fl_stall_recover high in cycle k+1 → fl_recover high cycles k+2..k+1+n → busy low at cycle k+2+n.

Test Plan:
1. Reset; disp_req=1 for 5 cycles with fl_p_rd_new=32,33,34,35,36, fl_empty=0 → disp_grant and fl_reg_wen high 5 cycles; hist_cnt=5; err=0.
2. fl_empty=1 with disp_req=1 → disp_grant=0, fl_reg_wen=0, hist_cnt stays 5.
3. From state of test 1: flush_req with flush_cnt=3 →
   - one cycle fl_stall_recover=1;
   - then 3 cycles fl_recover=1 with fl_PR_new_flush=36,35,34;
   - hist_cnt=2; busy low 5 cycles after the flush edge;
   - disp_req held high throughout gets no grant until busy=0.
4. ret_valid=1, ret_p_rd_old=31 concurrent with a granted dispatch → fl_retire_reg=1, fl_p_rd_old=31, hist_cnt unchanged. Repeat with hist_cnt=0 → no pop, err=1.
5. Wrap and clamp:
   - Push 40 allocations interleaved with 20 retires so pointers wrap; then fill to 32 → disp_grant=0 at full.
   - flush_cnt=40 → clamps to 32: 32 walk cycles returning the PRs in reverse allocation order; hist_cnt=0.
6. Assert rst asynchronously in the 2nd WALK cycle → fl_recover, busy, hist_cnt, fl_PR_new_flush all 0 before the next edge. After release, dispatch is granted normally and err=0.
